// File: rtl/clock_text_fetch_if.sv
// Glyph ROM port of the clock text fetcher: registered address out, row data back one cycle later.
interface clock_text_fetch_if;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/clock_text_fetch.sv
// Per-scanline glyph fetch for the "HH:MM:SS"+alarm text field and its 1-bit pixel serialiser.
// Optional: define COLON_BLINK_EN to blank both colons while the seconds units digit is odd.
module clock_text_fetch #(
    parameter int X0         = 256,
    parameter int Y0         = 224,
    parameter int SCALE_LOG2 = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_line_start,
    input  logic [9:0]         i_next_y,
    input  logic [7:0]         i_hh,
    input  logic [7:0]         i_mm,
    input  logic [7:0]         i_ss,
    input  logic               i_alarm_on,
    clock_text_fetch_if.master rom,
    output logic               o_busy,
    output logic               o_fetch_done,
    input  logic [9:0]         i_pixel_x,
    input  logic [9:0]         i_pixel_y,
    output logic               o_text_on
);
    localparam logic [9:0] X0_L  = 10'(X0);
    localparam logic [9:0] Y0_L  = 10'(Y0);
    localparam int         NCHAR = 9;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    // Character descriptors are {blank, code[6:0]}; a blank still addresses code 0x30.
    function automatic logic [7:0] digit_code(input logic [3:0] d);
        return (d > 4'd9) ? 8'hB0 : {1'b0, 3'b011, d};
    endfunction

    function automatic logic [7:0] char_sel(input logic [3:0] idx, input logic [7:0] hh,
                                            input logic [7:0] mm, input logic [7:0] ss,
                                            input logic alarm);
        logic [7:0] colon;
`ifdef COLON_BLINK_EN
        colon = ss[0] ? 8'hB0 : 8'h3A;
`else
        colon = 8'h3A;
`endif
        case (idx)
            4'd0:    char_sel = digit_code(hh[7:4]);
            4'd1:    char_sel = digit_code(hh[3:0]);
            4'd2:    char_sel = colon;
            4'd3:    char_sel = digit_code(mm[7:4]);
            4'd4:    char_sel = digit_code(mm[3:0]);
            4'd5:    char_sel = colon;
            4'd6:    char_sel = digit_code(ss[7:4]);
            4'd7:    char_sel = digit_code(ss[3:0]);
            4'd8:    char_sel = alarm ? 8'h3B : 8'hB0;
            default: char_sel = 8'hB0;
        endcase
    endfunction

    state_t           r_state, w_state_next;
    logic [3:0]       r_idx;
    logic [7:0]       r_hh, r_mm, r_ss;
    logic             r_alarm;
    logic             r_in_band, r_front_in_band;
    logic [3:0]       r_glyph_row;
    logic [10:0]      r_rom_addr;
    logic             r_fetch_done, r_text_on;
    logic [7:0]       r_back  [NCHAR];
    logic [7:0]       r_front [NCHAR];

    logic [9:0]       w_dy, w_row_full, w_dx, w_cx;
    logic             w_in_band_new, w_in_field;
    logic [7:0]       w_char0, w_next_char, w_cap_char, w_cap_data;
    logic             w_cap_en, w_commit, w_addr_step;
    logic [3:0]       w_cap_idx;
    logic [NCHAR-1:0] w_cap_hit;
    logic [127:0]     w_line_bits;
    logic             w_unused;

    assign w_dy          = i_next_y - Y0_L;
    assign w_row_full    = w_dy >> SCALE_LOG2;
    assign w_in_band_new = (i_next_y >= Y0_L) && (w_row_full < 10'd16);
    // Character 0 is addressed straight from the live inputs on the start edge.
    assign w_char0       = char_sel(4'd0, i_hh, i_mm, i_ss, i_alarm_on);
    assign w_next_char   = char_sel(r_idx + 4'd1, r_hh, r_mm, r_ss, r_alarm);
    assign w_cap_char    = char_sel(w_cap_idx, r_hh, r_mm, r_ss, r_alarm);
    assign w_cap_data    = (r_in_band && !w_cap_char[7]) ? rom.rom_data : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_cap_en     = 1'b0;
        w_cap_idx    = r_idx - 4'd1;
        w_commit     = 1'b0;
        w_addr_step  = 1'b0;
        case (r_state)
            S_IDLE: if (i_line_start) w_state_next = S_FETCH;
            S_FETCH: begin
                w_cap_en    = (r_idx != 4'd0);
                w_addr_step = (r_idx != 4'd8);
                if (i_line_start)       w_state_next = S_FETCH;
                else if (r_idx == 4'd8) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Commit always completes; a coincident line_start chains straight into a new fetch.
                w_cap_en     = 1'b1;
                w_cap_idx    = 4'd8;
                w_commit     = 1'b1;
                w_state_next = i_line_start ? S_FETCH : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NCHAR; gi++) begin : g_char
            assign w_cap_hit[gi] = w_cap_en && (w_cap_idx == 4'(gi));
            for (genvar gk = 0; gk < 8; gk++) begin : g_bit
                assign w_line_bits[8*gi + gk] = r_front[gi][7-gk];
            end
        end
    endgenerate
    assign w_line_bits[127:8*NCHAR] = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx           <= '0;
            r_hh            <= '0;
            r_mm            <= '0;
            r_ss            <= '0;
            r_alarm         <= 1'b0;
            r_in_band       <= 1'b0;
            r_front_in_band <= 1'b0;
            r_glyph_row     <= '0;
            r_rom_addr      <= '0;
            r_fetch_done    <= 1'b0;
            for (int i = 0; i < NCHAR; i++) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
        end else begin
            r_fetch_done <= w_commit;
            if (i_line_start) begin
                r_hh        <= i_hh;
                r_mm        <= i_mm;
                r_ss        <= i_ss;
                r_alarm     <= i_alarm_on;
                r_in_band   <= w_in_band_new;
                r_glyph_row <= w_row_full[3:0];
                r_rom_addr  <= {w_char0[6:0], w_row_full[3:0]};
                r_idx       <= 4'd0;
            end else if (w_addr_step) begin
                r_rom_addr <= {w_next_char[6:0], r_glyph_row};
                r_idx      <= r_idx + 4'd1;
            end
            for (int i = 0; i < NCHAR; i++) begin
                if (w_cap_hit[i]) r_back[i] <= w_cap_data;
                if (w_commit)     r_front[i] <= (i == NCHAR-1) ? w_cap_data : r_back[i];
            end
            if (w_commit) r_front_in_band <= r_in_band;
        end
    end

    // Vertical band was resolved at fetch time, so only the column matters here.
    assign w_dx       = i_pixel_x - X0_L;
    assign w_cx       = w_dx >> SCALE_LOG2;
    assign w_in_field = (i_pixel_x >= X0_L) && (w_cx < 10'd72);

    always_ff @(posedge clk) begin
        if (reset) r_text_on <= 1'b0;
        else       r_text_on <= w_in_field && r_front_in_band && w_line_bits[w_cx[6:0]];
    end

    assign rom.rom_addr = r_rom_addr;
    assign o_busy       = (r_state != S_IDLE);
    assign o_fetch_done = r_fetch_done;
    assign o_text_on    = r_text_on;
    assign w_unused     = ^{i_pixel_y, w_char0[7], w_next_char[7], w_cap_char[6:0]};
endmodule
